fir_serial_deserializer: RTL

Downstream stage of the serial FIR filter top level. Accepts the filter's bit-serial output stream (LSB first, valid/ready handshake) and reassembles DATA_WIDTH-bit samples. Buffers completed samples in a small first-word-fall-through FIFO. Presents them on a parallel valid/ready interface to the capture/DAC side.

---
 rtl/fir_serial_deserializer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/fir_serial_deserializer.sv
// Reassembles an LSB-first bit-serial stream into DATA_WIDTH-bit words and buffers them in a FWFT FIFO.
// Optional mid-word stall timeout is compiled in with `define FIR_DESER_TIMEOUT_EN.
module fir_serial_deserializer #(
  parameter int DATA_WIDTH     = 24,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_en,
  input  logic                          i_sdata,
  input  logic                          i_sdata_valid,
  output logic                          o_sready,
  output logic [DATA_WIDTH-1:0]         o_pdata,
  output logic                          o_pvalid,
  input  logic                          i_pready,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic                          o_frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  // Handshakes: a serial beat is a rising edge with i_sdata_valid && o_sready;
  // a parallel pop is a rising edge with o_pvalid && i_pready. Neither valid may depend on its ready.

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]   sreg_q, sreg_d;
  logic                    run_q;
  logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [AW:0]             wptr_q, rptr_q;
  logic [DATA_WIDTH-1:0]   last_q;
  logic                    full, empty, beat, push, pop, timeout;

  assign empty        = (wptr_q == rptr_q);
  assign full         = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign o_fifo_count = wptr_q - rptr_q;
  assign o_pvalid     = !empty;
  assign o_pdata      = empty ? last_q : mem[rptr_q[AW-1:0]];
  assign pop          = o_pvalid && i_pready;

  // A word only starts when a FIFO slot is free, so SHIFT never needs a fullness check.
  // run_q keeps ready low while in reset and for the first edge after release.
  assign o_sready = run_q && i_en && ((state_q == SHIFT) || !full);
  assign beat     = i_sdata_valid && o_sready;

`ifdef FIR_DESER_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT_CYCLES + 1);
  logic [SW-1:0] stall_q;
  logic          err_q;

  // Fires on the edge that would be the TIMEOUT_CYCLES-th consecutive beat-less SHIFT cycle.
  assign timeout     = (state_q == SHIFT) && !beat && (stall_q == SW'(TIMEOUT_CYCLES - 1));
  assign o_frame_err = err_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= timeout;
      if ((state_q != SHIFT) || beat || timeout) stall_q <= '0;
      else                                       stall_q <= stall_q + SW'(1);
    end
  end
`else
  assign timeout     = 1'b0;
  assign o_frame_err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sreg_d    = sreg_q;
    push      = 1'b0;
    case (state_q)
      IDLE: begin
        if (beat) begin
          sreg_d    = {{(DATA_WIDTH-1){1'b0}}, i_sdata};
          bit_cnt_d = CW'(1);
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (beat) begin
          sreg_d[bit_cnt_q] = i_sdata;
          if (bit_cnt_q == LAST_BIT) begin
            push      = 1'b1;
            bit_cnt_d = '0;
            state_d   = IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end else if (timeout) begin
          bit_cnt_d = '0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      sreg_q    <= '0;
      run_q     <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      last_q    <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sreg_q    <= sreg_d;
      run_q     <= 1'b1;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
        last_q <= mem[rptr_q[AW-1:0]];
      end
    end
  end

  // Completed word goes straight from the shift path into the FIFO on the final-bit edge.
  always_ff @(posedge i_clk) begin
    if (push) mem[wptr_q[AW-1:0]] <= sreg_d;
  end

endmodule
